// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default reset PC, canonical NOP, queue entry type, PC alignment helper.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low bits of a target are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the imem request/response, redirect and decode handshakes of the fetch stage.
// Latency: n/a (wires only).
// Backpressure: imem_gnt stalls requests, id_ready stalls delivery to decode.
// Ports: master = fetch unit side, slave = memory/decode/branch side.
interface instr_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [24:0] id_imm;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, id_imm,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_imm,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// In-order queue of fetched {pc, instr} entries.
// Latency: a push is visible at head the cycle after it is written.
// Backpressure: none internally; the caller never pushes when full or pops when empty.
// Ports: clk/reset, push + push_entry, pop, flush (beats push), count, empty, head.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output fetch_entry_t             head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr[AW-1:0]] <= push_entry;
  end

  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign head  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues imem word requests, queues responses for decode.
// Latency: gnt with req and rvalid one cycle later gives id_valid two cycles after the request.
// Backpressure: requests stop once queued + outstanding reaches FIFO_DEPTH; id_ready holds the head.
// Ports: clk, reset (sync, active high), bus (instr_fetch_unit_if.master).
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   target;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [CW:0]   inflight;
  logic          empty;
  logic          issue;
  logic          drop;
  logic          push;
  logic          pop;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  assign target = word_align(bus.redirect_pc);

  // Queue space is reserved at issue time, so a response can always be pushed.
  assign inflight     = {1'b0, count} + {1'b0, outstanding};
  assign bus.imem_req  = !reset && (inflight < (CW+1)'(FIFO_DEPTH));
  assign bus.imem_addr = fetch_pc;

  assign issue = bus.imem_req && bus.imem_gnt;
  assign drop  = (discard != '0);
  // A response arriving in the redirect cycle belongs to the old stream.
  assign push  = bus.imem_rvalid && !drop && !bus.redirect_valid;
  assign pop   = bus.id_valid && bus.id_ready;

  assign outstanding_nxt = outstanding + CW'(issue) - CW'(bus.imem_rvalid);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (bus.redirect_valid) begin
        // Everything still in flight after this cycle's accounting is stale.
        fetch_pc <= target;
        resp_pc  <= target;
        discard  <= outstanding_nxt;
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (push)  resp_pc  <= resp_pc + 32'd4;
        if (bus.imem_rvalid && drop) discard <= discard - CW'(1);
      end
    end
  end

  assign push_entry = '{pc: resp_pc, instr: bus.imem_rdata};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (bus.redirect_valid),
    .count      (count),
    .empty      (empty),
    .head       (head)
  );

  // An empty queue presents a NOP at the reset PC so decode never sees stale data.
  assign bus.id_valid = !empty;
  assign bus.id_instr = empty ? NOP_INSTR : head.instr;
  assign bus.id_pc    = empty ? RESET_PC  : head.pc;
  assign bus.id_imm   = bus.id_instr[31:7];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random imem/decode timing, in-order memory model, pc-stream scoreboard.
// Latency: directed checks for first-fetch latency, stalls, redirects and reset.
// Backpressure: gnt, rvalid and id_ready are throttled by percentage knobs.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          t;
  } pend_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pops     = 0;
  int gnt_pct  = 100;
  int rv_pct   = 100;
  int rdy_pct  = 100;

  pend_t       pend_q[$];   // granted requests awaiting a response, in order
  logic [31:0] exp_q[$];    // pcs decode is expected to receive next
  logic [31:0] fill_pc;
  logic [31:0] next_fetch;
  logic        prev_stall;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A13;
  endfunction

  function automatic logic pct(input int p);
    return ($urandom_range(99) < p);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory + decode-ready driver and stream model; drives at negedge, samples 4ns later.
  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.id_ready    = 1'b0;
    prev_stall      = 1'b0;
    fill_pc         = RST_PC;
    next_fetch      = RST_PC;
    forever begin
      @(negedge clk);
      cyc++;
      bus.imem_gnt = pct(gnt_pct);
      if (pend_q.size() > 0 && pend_q[0].t <= cyc && pct(rv_pct)) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(pend_q[0].addr);
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
      end
      bus.id_ready = pct(rdy_pct);
      #4;
      if (reset) begin
        pend_q.delete();
        exp_q.delete();
        fill_pc    = RST_PC;
        next_fetch = RST_PC;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) chk("req_hold", {31'b0, bus.imem_req}, 32'd1);
        if (bus.imem_req) chk("imem_addr", bus.imem_addr, next_fetch);
        if (bus.imem_rvalid) void'(pend_q.pop_front());
        if (bus.imem_req && bus.imem_gnt) begin
          pend_q.push_back('{addr: bus.imem_addr, t: cyc + 1});
          next_fetch += 32'd4;
          chk("max_outstanding_ok", {31'b0, pend_q.size() <= 2}, 32'd1);
        end
        prev_stall = bus.imem_req && !bus.imem_gnt && !bus.redirect_valid;
        if (bus.redirect_valid) begin
          next_fetch = {bus.redirect_pc[31:2], 2'b00};
          fill_pc    = {bus.redirect_pc[31:2], 2'b00};
          exp_q.delete();
        end
      end
      while (exp_q.size() < 8) begin
        exp_q.push_back(fill_pc);
        fill_pc += 32'd4;
      end
    end
  end

  // Decode-side monitor: every accepted instruction must be the next pc of the current stream.
  initial begin
    logic [31:0] e;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      #4;
      if (!reset && !bus.redirect_valid && bus.id_valid && bus.id_ready) begin
        if (exp_q.size() == 0) begin
          chk("exp_queue_nonempty", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          w = mem_word(e);
          chk("id_pc", bus.id_pc, e);
          chk("id_instr", bus.id_instr, w);
          chk("id_imm", {7'b0, bus.id_imm}, {7'b0, w[31:7]});
          pops++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #4;
    end
  endtask

  initial begin
    int   base;
    logic found;
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    #4;
    chk("rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_id_valid", {31'b0, bus.id_valid}, 32'd0);
    chk("rst_id_instr", bus.id_instr, NOP);
    chk("rst_id_pc", bus.id_pc, RST_PC);
    chk("rst_id_imm", {7'b0, bus.id_imm}, {7'b0, NOP[31:7]});
    chk("rst_imem_addr", bus.imem_addr, RST_PC);

    // First request and two-cycle latency.
    @(negedge clk);
    reset = 1'b0;
    #4;
    chk("first_req", {31'b0, bus.imem_req}, 32'd1);
    step(1);
    chk("lat_c1_valid", {31'b0, bus.id_valid}, 32'd0);
    step(1);
    chk("lat_c2_valid", {31'b0, bus.id_valid}, 32'd1);
    chk("lat_c2_pc", bus.id_pc, RST_PC);

    // Sequential stream across the 32-bit wrap.
    base = pops;
    step(20);
    chk("seq_progress", {31'b0, (pops - base) >= 10}, 32'd1);

    // Decode stall fills the queue and stops requests.
    rdy_pct = 0;
    step(2);
    repeat (3) begin
      step(1);
      chk("stall_valid", {31'b0, bus.id_valid}, 32'd1);
      chk("stall_pc", bus.id_pc, exp_q[0]);
      chk("stall_instr", bus.id_instr, mem_word(exp_q[0]));
    end
    chk("stall_req_low", {31'b0, bus.imem_req}, 32'd0);
    rdy_pct = 100;
    step(10);

    // Grant withheld: request and address held.
    gnt_pct = 0;
    step(2);
    repeat (3) begin
      step(1);
      chk("nogrant_req", {31'b0, bus.imem_req}, 32'd1);
      chk("nogrant_addr", bus.imem_addr, next_fetch);
    end
    gnt_pct = 100;
    step(10);

    // Redirect with two stale requests outstanding.
    rv_pct = 0;
    step(5);
    chk("two_outstanding", pend_q.size(), 32'd2);
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    #4;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    rv_pct = 100;
    #4;
    chk("redir_valid_low", {31'b0, bus.id_valid}, 32'd0);
    chk("redir_addr", bus.imem_addr, 32'h0000_0100);
    base = pops;
    step(10);
    chk("redir_progress", {31'b0, (pops - base) >= 3}, 32'd1);

    // Redirect coinciding with a grant and a response.
    for (int k = 0; k < 3; k++) begin
      found = 1'b0;
      for (int t = 0; t < 50 && !found; t++) begin
        @(negedge clk);
        #1;
        if (bus.imem_req && bus.imem_gnt && bus.imem_rvalid) begin
          bus.redirect_valid = 1'b1;
          bus.redirect_pc    = $urandom;
          found = 1'b1;
        end
        #3;
      end
      chk("coincide_found", {31'b0, found}, 32'd1);
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      #4;
      chk("coincide_valid_low", {31'b0, bus.id_valid}, 32'd0);
      step(8);
    end

    // Randomized traffic with occasional redirects.
    base = pops;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) begin
        gnt_pct = $urandom_range(100, 20);
        rv_pct  = $urandom_range(100, 20);
        rdy_pct = $urandom_range(100, 20);
      end
      @(negedge clk);
      bus.redirect_valid = ($urandom_range(99) < 3);
      bus.redirect_pc    = $urandom;
      #4;
    end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    gnt_pct = 100;
    rv_pct  = 100;
    rdy_pct = 100;
    #4;
    chk("random_progress", {31'b0, (pops - base) >= 300}, 32'd1);
    step(5);

    // Reset mid-stream.
    @(negedge clk);
    reset = 1'b1;
    #4;
    @(negedge clk);
    reset = 1'b0;
    #4;
    chk("midrst_valid", {31'b0, bus.id_valid}, 32'd0);
    chk("midrst_addr", bus.imem_addr, RST_PC);
    base = pops;
    step(20);
    chk("midrst_progress", {31'b0, (pops - base) >= 10}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage feeding the decode/immediate-extend logic.
- Owns the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid interface.
- Buffers returned instructions in a small in-order queue and presents them to decode over a valid/ready handshake, with pc and the Instr[31:7] immediate field.
- Accepts a single-cycle redirect (branch/jump target) that flushes the queue and discards in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- FIFO_DEPTH, 2, instruction queue entries; also caps outstanding requests (power of 2, ≥2).

Ports:
- clk  input  1  clock; everything on rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  word-aligned fetch address; bits [1:0] always 0.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response data valid; responses arrive in request order, ≥1 cycle after gnt.
- imem_rdata  input  32  instruction word.
- redirect_valid  input  1  one-cycle redirect strobe.
- redirect_pc  input  32  redirect target; bits [1:0] ignored, forced to 0.
- id_valid  output  1  decode-side instruction valid.
- id_ready  input  1  decode accepts.
- id_instr  output  32  instruction at queue head.
- id_pc  output  32  address of id_instr.
- id_imm  output  25  id_instr[31:7], the immediate source for the extender.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=RESET_PC, id_imm=id_instr[31:7].
  - Internal: fetch_pc=RESET_PC, resp_pc=RESET_PC, queue empty, outstanding=0, discard=0.
- Request side:
  - imem_req=1 when !reset and (count+outstanding) < FIFO_DEPTH; imem_addr=fetch_pc.
  - While imem_req=1 and imem_gnt=0, req and addr stay stable unless a redirect occurs.
  - On req&gnt: fetch_pc += 4 (mod 2^32; 0xFFFF_FFFC wraps to 0), outstanding += 1.
- Response side, on rvalid:
  - outstanding -= 1.
  - If discard>0: discard -= 1 and the data is dropped.
  - Otherwise push {resp_pc, rdata} and resp_pc += 4.
  - Space is pre-reserved by the issue gating, so a push never meets a full queue.
- Decode side:
  - id_valid=1 iff queue non-empty; outputs come from the queue head.
  - Pop on id_valid&id_ready. Outputs are stable while id_valid&!id_ready.
  - Push and pop in the same cycle are both honoured.
- Latency: with gnt in the same cycle as req and rvalid on the next cycle, id_valid rises 2 cycles after the request cycle. The first req is in the first cycle after reset deasserts.
- Redirect (redirect_valid=1 in cycle T):
  - Queue flushed at the T edge; id_valid=0 at T+1. A pop in cycle T is irrelevant.
  - fetch_pc and resp_pc ← {redirect_pc[31:2],2'b00}.
  - discard ← outstanding after T's gnt/rvalid accounting. That includes a request granted in T, and an rvalid in T is dropped.
  - imem_req may deassert or change address from T+1 onward. The first request at the target is issued at T+1 if space allows.
- Back-to-back redirects: each recomputes discard; the last target wins.
- Reset mid-operation: all state returns to reset values. Responses to pre-reset requests are the memory's responsibility and are not expected after reset.

Decomposition:
- Shared package (fetch_pkg):
  - constant RESET_PC_DEFAULT.
  - constant NOP_INSTR=32'h0000_0013.
  - typedef fetch_entry_t {pc[31:0], instr[31:0]}.
- One sub-module, fetch_fifo: synchronous FIFO of fetch_entry_t.
  - Parameters: DEPTH.
  - Ports: push, pop, flush, count, empty, head.
  - flush has priority over push.
- Top level holds the PC, outstanding/discard counters and the issue gating.

Test Plan:
- Reset then sequential fetch, gnt tied 1, rvalid 1 cycle later, id_ready=1 → id_pc sequence 0x0,0x4,0x8…; id_imm equals id_instr[31:7]; first id_valid 2 cycles after first req.
- id_ready=0 for 5 cycles → queue fills to 2, imem_req drops to 0, id_instr/id_pc held; on release, no instruction lost or duplicated.
- imem_gnt=0 for 3 cycles → imem_req=1 and imem_addr held constant; fetch resumes at the same address.
- 2 requests outstanding, redirect_pc=0x0000_0103 → both stale responses dropped, id_valid low next cycle, next id_pc=0x0000_0100.
- Redirect coinciding with gnt and rvalid in the same cycle → discard accounting correct; only target-stream instructions reach decode.
- RESET_PC=0xFFFF_FFF8 → id_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; reset asserted mid-stream → id_valid=0 and imem_addr=RESET_PC next cycle.
